// File: rtl/aftab_seq_compare_ctrl.sv
// Multi-cycle signed/unsigned magnitude compare over a shared slice.
// MSB slice first; stops at the first differing slice.
module aftab_seq_compare_ctrl #(
  parameter int size       = 32,
  parameter int sliceWidth = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            comparedSignedUnsignedBar,
  output logic            busy,
  output logic            done,
  output logic            lt,
  output logic            eq,
  output logic            gt
);

  localparam int nSlice = size / sliceWidth;
  localparam int idxW   = (nSlice > 1) ? $clog2(nSlice) : 1;
  localparam logic [idxW-1:0] idxTop = idxW'(nSlice - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  logic [size-1:0]       aa;
  logic [size-1:0]       bb;
  logic [idxW-1:0]       idx;
  logic [sliceWidth-1:0] sa;
  logic [sliceWidth-1:0] sb;
  logic                  accept;
  logic                  sliceLt;
  logic                  sliceGt;
  logic                  sliceEq;
  logic                  lastSlice;

  // Select the slice currently under examination.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < nSlice; i++) begin
      if (idx == i[idxW-1:0]) begin
        sa = aa[i*sliceWidth +: sliceWidth];
        sb = bb[i*sliceWidth +: sliceWidth];
      end
    end
  end

  assign sliceLt   = sa < sb;
  assign sliceGt   = sa > sb;
  assign sliceEq   = sa == sb;
  assign lastSlice = idx == '0;
  assign accept    = start && (state == IDLE || state == DONE);

  // Next-state and status decode.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) stateNext = COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        if (!sliceEq || lastSlice) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = start ? COMPARE : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Operand capture, slice walk and result flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      aa  <= '0;
      bb  <= '0;
      idx <= '0;
      lt  <= 1'b0;
      eq  <= 1'b0;
      gt  <= 1'b0;
    end else if (accept) begin
      // Flipping the sign bit maps two's-complement order onto unsigned order.
      aa  <= {a[size-1] ^ comparedSignedUnsignedBar, a[size-2:0]};
      bb  <= {b[size-1] ^ comparedSignedUnsignedBar, b[size-2:0]};
      idx <= idxTop;
      lt  <= 1'b0;
      eq  <= 1'b0;
      gt  <= 1'b0;
    end else if (state == COMPARE) begin
      unique case (1'b1)
        sliceLt:                 lt  <= 1'b1;
        sliceGt:                 gt  <= 1'b1;
        sliceEq && lastSlice:    eq  <= 1'b1;
        sliceEq && !lastSlice:   idx <= idx - idxW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_seq_compare_ctrl.sv
// Bench for aftab_seq_compare_ctrl: directed and random compares
// checked against an arithmetic reference model.
module tb_aftab_seq_compare_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        busy;
  logic        done;
  logic        lt;
  logic        eq;
  logic        gt;

  int passCnt = 0;
  int failCnt = 0;
  int total   = 0;

  aftab_seq_compare_ctrl #(.size(32), .sliceWidth(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .comparedSignedUnsignedBar(sgn),
    .busy(busy),
    .done(done),
    .lt(lt),
    .eq(eq),
    .gt(gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: 3-bit {lt,eq,gt} from plain arithmetic.
  function automatic logic [2:0] refFlags(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic s);
    if (s) begin
      if ($signed(x) < $signed(y)) return 3'b100;
      if ($signed(x) > $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
    return 3'b010;
  endfunction

  // Reference: number of byte slices examined, MSB first.
  function automatic int refK(input logic [31:0] x, input logic [31:0] y);
    for (int i = 3; i >= 0; i--) begin
      if (x[i*8 +: 8] != y[i*8 +: 8]) return 4 - i;
    end
    return 4;
  endfunction

  // Called just after an edge. Drives start, checks one full operation.
  // chain: leave the bench sitting in DONE for a back-to-back start.
  // poke: pulse start with other operands while busy.
  task automatic runOp(input logic [31:0] ta, input logic [31:0] tb2,
                       input logic ts, input bit chain, input bit poke,
                       input string tag);
    logic [2:0] expF;
    int         expK;
    int         edges;
    int         busyCnt;
    int         badBusy;
    expF = refFlags(ta, tb2, ts);
    expK = refK(ta, tb2);
    start = 1'b1;
    a = ta;
    b = tb2;
    sgn = ts;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sgn = 1'($urandom);
    chk({tag, "_acceptBusy"}, 32'({busy, done}), 32'(2'b10));
    edges = 1;
    busyCnt = 0;
    badBusy = 0;
    while (!done && edges < 20) begin
      if (busy) begin
        busyCnt++;
        if ({lt, eq, gt} != 3'b000) badBusy++;
      end
      start = (poke && edges == 2) ? 1'b1 : 1'b0;
      step();
      start = 1'b0;
      edges++;
    end
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_lat"}, 32'(edges), 32'(expK + 1));
    chk({tag, "_busyCyc"}, 32'(busyCnt), 32'(expK));
    chk({tag, "_flagsBusy"}, 32'(badBusy), 32'(0));
    chk({tag, "_flags"}, 32'({lt, eq, gt}), 32'(expF));
    if (!chain) begin
      step();
      chk({tag, "_pulse"}, 32'({busy, done}), 32'(2'b00));
      step();
      step();
      chk({tag, "_hold"}, 32'({lt, eq, gt}), 32'(expF));
    end
  endtask

  initial begin
    int doneSeen;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    sgn = 1'b0;
    step();
    step();
    chk("rst_status", 32'({busy, done}), 32'(0));
    chk("rst_flags", 32'({lt, eq, gt}), 32'(0));
    rst = 1'b1;
    step();

    runOp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0, "uMsb");
    runOp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 0, "sMsb");
    runOp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0, 0, "sEq");
    runOp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 0, "uEq");
    runOp(32'h1234_5600, 32'h1234_56FF, 1'b0, 0, 0, "uLsb");
    runOp(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 0, 0, "sNeg");
    runOp(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0, 0, "sPos");
    runOp(32'hCAFE_0000, 32'hCAFE_0000, 1'b0, 0, 1, "poke");

    // Back-to-back: start held into DONE.
    runOp(32'h0000_00FF, 32'h0000_00FE, 1'b0, 1, 0, "b2b1");
    runOp(32'h8000_0000, 32'h0000_0000, 1'b1, 0, 0, "b2b2");

    // Reset in the middle of a compare.
    start = 1'b1;
    a = 32'h5555_5555;
    b = 32'h5555_5555;
    sgn = 1'b0;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    chk("midRst_status", 32'({busy, done}), 32'(0));
    chk("midRst_flags", 32'({lt, eq, gt}), 32'(0));
    rst = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) doneSeen++;
    end
    chk("midRst_noDone", 32'(doneSeen), 32'(0));

    // Random operands with random numbers of matching leading slices.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = ra;
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 2) == 0) rb[s*8 +: 8] = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) rb = $urandom;
      runOp(ra, rb, 1'($urandom), bit'($urandom_range(0, 1)), 0, "rnd");
    end
    step();
    step();

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
